// File: rtl/dcache_ctrl.sv
// dcache_ctrl -- direct-mapped, write-back, write-allocate L1 data-cache
// controller for the MEM stage.
//
// Holds the tag, valid and dirty state and the line data. Sequences line
// write-backs and refills to main memory. Stalls the pipeline while a miss
// is being serviced.
//
// Ports
//   clk_i, rst_i      clock; asynchronous active-high reset
//   cpu_req_i         MEM-stage access request
//   cpu_we_i          1 = store, 0 = load
//   cpu_addr_i        byte address ([1:0] ignored)
//   cpu_data_i        store data
//   cpu_data_o        load data (combinational on a hit, 0 otherwise)
//   cpu_stall_o       pipeline stall
//   mem_req_o         memory request, held until mem_ack_i
//   mem_we_o          1 = line write-back, 0 = line fetch
//   mem_addr_o        line-aligned memory address
//   mem_data_o        write-back line data
//   mem_data_i        fetched line data
//   mem_ack_i         single-cycle completion pulse
//
// state     | meaning
// ----------+--------------------------------------------------------
// IDLE      | serve hits; on a miss pick WRITEBACK or ALLOCATE
// WRITEBACK | write the dirty victim line to memory, wait for ack
// ALLOCATE  | fetch the missing line, capture it on ack
// FILL      | install the fetched line, then return to IDLE
module dcache_ctrl #(
  parameter int INDEX_W  = 4,
  parameter int LINE_W   = 256,
  parameter int OFFSET_W = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [31:0]       cpu_addr_i,
  input  logic [31:0]       cpu_data_i,
  output logic [31:0]       cpu_data_o,
  output logic              cpu_stall_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [31:0]       mem_addr_o,
  output logic [LINE_W-1:0] mem_data_o,
  input  logic [LINE_W-1:0] mem_data_i,
  input  logic              mem_ack_i
);

  localparam int TAG_W  = 32 - INDEX_W - OFFSET_W;
  localparam int LINES  = 1 << INDEX_W;
  localparam int WORDS  = LINE_W / 32;
  localparam int WSEL_W = $clog2(WORDS);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WRITEBACK = 2'd1,
    S_ALLOCATE  = 2'd2,
    S_FILL      = 2'd3
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [LINES-1:0]  r_valid;
  logic [LINES-1:0]  r_dirty;
  logic [TAG_W-1:0]  r_tag  [LINES];
  logic [LINE_W-1:0] r_data [LINES];
  logic [LINE_W-1:0] r_fill_buf;

  // Miss address is latched so an in-flight refill stays self-consistent
  // even if the requester drops or changes its address mid-miss.
  logic [TAG_W-1:0]   r_miss_tag;
  logic [INDEX_W-1:0] r_miss_index;

  logic [TAG_W-1:0]   w_tag;
  logic [INDEX_W-1:0] w_index;
  logic [WSEL_W-1:0]  w_wsel;
  logic [LINE_W-1:0]  w_line;
  logic               w_hit;
  logic               w_idle_hit;
  logic               w_store_hit;
  logic               w_miss;
  logic               w_unused;

  assign w_tag   = cpu_addr_i[31 -: TAG_W];
  assign w_index = cpu_addr_i[OFFSET_W +: INDEX_W];
  assign w_wsel  = cpu_addr_i[2 +: WSEL_W];
  assign w_line  = r_data[w_index];

  // Byte-lane bits are not used by a word-only interface.
  assign w_unused = &{1'b0, cpu_addr_i[1:0]};

  assign w_hit       = r_valid[w_index] && (r_tag[w_index] == w_tag);
  assign w_idle_hit  = (r_state == S_IDLE) && w_hit;
  assign w_store_hit = w_idle_hit && cpu_req_i && cpu_we_i;
  assign w_miss      = (r_state == S_IDLE) && cpu_req_i && !w_hit;

  assign cpu_stall_o = cpu_req_i && !w_idle_hit;
  assign cpu_data_o  = w_hit ? w_line[w_wsel*32 +: 32] : 32'h0;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state      <= S_IDLE;
      r_valid      <= '0;
      r_dirty      <= '0;
      r_miss_tag   <= '0;
      r_miss_index <= '0;
    end else begin
      r_state <= w_next;
      if (w_miss) begin
        r_miss_tag   <= w_tag;
        r_miss_index <= w_index;
      end
      if (w_store_hit) begin
        r_dirty[w_index] <= 1'b1;
      end
      if (r_state == S_FILL) begin
        r_valid[r_miss_index] <= 1'b1;
        r_dirty[r_miss_index] <= 1'b0;
      end
    end
  end

  // Data, tag and fill-buffer storage carry no reset.
  always_ff @(posedge clk_i) begin
    if ((r_state == S_ALLOCATE) && mem_ack_i) begin
      r_fill_buf <= mem_data_i;
    end
    if (r_state == S_FILL) begin
      r_data[r_miss_index] <= r_fill_buf;
      r_tag[r_miss_index]  <= r_miss_tag;
    end else if (w_store_hit) begin
      r_data[w_index][w_wsel*32 +: 32] <= cpu_data_i;
    end
  end

  always_comb begin
    w_next     = r_state;
    mem_req_o  = 1'b0;
    mem_we_o   = 1'b0;
    mem_addr_o = 32'h0;
    mem_data_o = '0;
    case (r_state)
      S_IDLE: begin
        if (w_miss) begin
          w_next = (r_valid[w_index] && r_dirty[w_index]) ? S_WRITEBACK : S_ALLOCATE;
        end
      end
      S_WRITEBACK: begin
        mem_req_o  = 1'b1;
        mem_we_o   = 1'b1;
        mem_addr_o = {r_tag[r_miss_index], r_miss_index, {OFFSET_W{1'b0}}};
        mem_data_o = r_data[r_miss_index];
        if (mem_ack_i) begin
          w_next = S_ALLOCATE;
        end
      end
      S_ALLOCATE: begin
        mem_req_o  = 1'b1;
        mem_addr_o = {r_miss_tag, r_miss_index, {OFFSET_W{1'b0}}};
        if (mem_ack_i) begin
          w_next = S_FILL;
        end
      end
      S_FILL: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl. A small memory model answers line
// requests after a per-access latency; written-back lines are remembered so
// a later refill returns them. Fresh lines hold {16'hC0DE, byte_addr[15:0]}
// in each word, so expected load data can be written down by hand.
module tb_dcache_ctrl;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b1;
  logic         cpu_req_i = 1'b0;
  logic         cpu_we_i = 1'b0;
  logic [31:0]  cpu_addr_i = 32'h0;
  logic [31:0]  cpu_data_i = 32'h0;
  logic [31:0]  cpu_data_o;
  logic         cpu_stall_o;
  logic         mem_req_o;
  logic         mem_we_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o;
  logic [255:0] mem_data_i = '0;
  logic         mem_ack_i = 1'b0;

  dcache_ctrl dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .cpu_req_i   (cpu_req_i),
    .cpu_we_i    (cpu_we_i),
    .cpu_addr_i  (cpu_addr_i),
    .cpu_data_i  (cpu_data_i),
    .cpu_data_o  (cpu_data_o),
    .cpu_stall_o (cpu_stall_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_data_o  (mem_data_o),
    .mem_data_i  (mem_data_i),
    .mem_ack_i   (mem_ack_i)
  );

  always #5 clk_i = ~clk_i;

  int nvec  = 0;
  int nfail = 0;

  logic [255:0] tbmem [logic [31:0]];

  int           stall_cnt;
  int           saw_wb;
  logic [31:0]  wb_addr;
  logic [31:0]  rd_addr;
  logic [255:0] wb_data;

  function automatic logic [255:0] mem_line(input logic [31:0] a);
    logic [255:0] l;
    if (tbmem.exists(a)) return tbmem[a];
    for (int k = 0; k < 8; k++) l[k*32 +: 32] = {16'hC0DE, a[15:0] + 16'(k*4)};
    return l;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Entered 1 time unit after a rising edge. Drives the access, services
  // memory requests with the given latencies (cycles from request rise to
  // ack, inclusive) and returns 3 units after the edge of the completing
  // cycle, with the access still presented.
  task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                        input int lwb, input int lrd);
    int cnt = 0;
    int budget = 0;
    cpu_req_i  = 1'b1;
    cpu_we_i   = we;
    cpu_addr_i = addr;
    cpu_data_i = wd;
    stall_cnt  = 0;
    saw_wb     = 0;
    wb_addr    = '0;
    rd_addr    = '0;
    wb_data    = '0;
    #2;
    while (cpu_stall_o && budget < 300) begin
      stall_cnt++;
      budget++;
      if (mem_req_o) begin
        cnt++;
        if (cnt == (mem_we_o ? lwb : lrd)) begin
          cnt = 0;
          mem_ack_i = 1'b1;
          if (mem_we_o) begin
            saw_wb  = 1;
            wb_addr = mem_addr_o;
            wb_data = mem_data_o;
            tbmem[mem_addr_o] = mem_data_o;
          end else begin
            rd_addr    = mem_addr_o;
            mem_data_i = mem_line(mem_addr_o);
          end
        end
      end
      @(posedge clk_i);
      #1;
      mem_ack_i = 1'b0;
      #2;
    end
    if (budget >= 300) chk("stall_timeout", {31'b0, cpu_stall_o}, 32'h0);
  endtask

  initial begin
    repeat (3) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    #2;
    chk("rst_stall",    {31'b0, cpu_stall_o}, 32'h0);
    chk("rst_mem_req",  {31'b0, mem_req_o},   32'h0);
    chk("rst_mem_we",   {31'b0, mem_we_o},    32'h0);
    chk("rst_mem_addr", mem_addr_o,           32'h0);
    chk("rst_mem_data", mem_data_o[31:0] | mem_data_o[255:224], 32'h0);
    chk("rst_cpu_data", cpu_data_o,           32'h0);
    step();

    // Clean load miss, L = 10.
    access(1'b0, 32'h0000_0040, 32'h0, 1, 10);
    chk("ld40_stall", stall_cnt,   32'd12);
    chk("ld40_wb",    saw_wb,      32'd0);
    chk("ld40_raddr", rd_addr,     32'h0000_0040);
    chk("ld40_data",  cpu_data_o,  32'hC0DE_0040);
    step();

    // Store hit, then loads from the same line.
    access(1'b1, 32'h0000_0044, 32'hDEAD_BEEF, 1, 1);
    chk("st44_stall", stall_cnt,  32'd0);
    step();
    access(1'b0, 32'h0000_0044, 32'h0, 1, 1);
    chk("ld44_stall", stall_cnt,  32'd0);
    chk("ld44_data",  cpu_data_o, 32'hDEAD_BEEF);
    step();
    access(1'b0, 32'h0000_0048, 32'h0, 1, 1);
    chk("ld48_data",  cpu_data_o, 32'hC0DE_0048);
    step();

    // Dirty conflict miss: Lwb = 3, Lrd = 4.
    access(1'b0, 32'h0000_0240, 32'h0, 3, 4);
    chk("ld240_stall", stall_cnt,       32'd9);
    chk("ld240_wb",    saw_wb,          32'd1);
    chk("ld240_waddr", wb_addr,         32'h0000_0040);
    chk("ld240_w0",    wb_data[31:0],   32'hC0DE_0040);
    chk("ld240_w1",    wb_data[63:32],  32'hDEAD_BEEF);
    chk("ld240_raddr", rd_addr,         32'h0000_0240);
    chk("ld240_data",  cpu_data_o,      32'hC0DE_0240);
    step();

    // Store miss, L = 1: fill then merge.
    access(1'b1, 32'h0000_1004, 32'h1234_5678, 1, 1);
    chk("st1004_stall", stall_cnt, 32'd3);
    chk("st1004_raddr", rd_addr,   32'h0000_1000);
    step();
    access(1'b0, 32'h0000_1004, 32'h0, 1, 1);
    chk("ld1004_data",  cpu_data_o, 32'h1234_5678);
    step();
    access(1'b0, 32'h0000_101C, 32'h0, 1, 1);
    chk("ld101c_data",  cpu_data_o, 32'hC0DE_101C);
    step();

    // Evict the stored-to line at index 0.
    access(1'b0, 32'h0000_0000, 32'h0, 2, 2);
    chk("ld0_stall", stall_cnt,        32'd6);
    chk("ld0_waddr", wb_addr,          32'h0000_1000);
    chk("ld0_w1",    wb_data[63:32],   32'h1234_5678);
    chk("ld0_w7",    wb_data[255:224], 32'hC0DE_101C);
    chk("ld0_data",  cpu_data_o,       32'hC0DE_0000);
    step();

    // Clean victim at index 2; refill returns the earlier written-back data.
    access(1'b0, 32'h0000_0044, 32'h0, 2, 2);
    chk("re44_stall", stall_cnt,  32'd4);
    chk("re44_wb",    saw_wb,     32'd0);
    chk("re44_data",  cpu_data_o, 32'hDEAD_BEEF);
    step();

    // Reset in the middle of ALLOCATE, with acks during and after reset.
    cpu_req_i  = 1'b1;
    cpu_we_i   = 1'b0;
    cpu_addr_i = 32'h0000_0060;
    @(posedge clk_i);
    #2;
    chk("mid_req",  {31'b0, mem_req_o}, 32'h1);
    chk("mid_we",   {31'b0, mem_we_o},  32'h0);
    chk("mid_addr", mem_addr_o,         32'h0000_0060);
    rst_i     = 1'b1;
    cpu_req_i = 1'b0;
    #1;
    chk("rst_mid_req",   {31'b0, mem_req_o},   32'h0);
    chk("rst_mid_addr",  mem_addr_o,           32'h0);
    chk("rst_mid_stall", {31'b0, cpu_stall_o}, 32'h0);
    mem_data_i = '1;
    mem_ack_i  = 1'b1;
    step();
    rst_i = 1'b0;
    step();
    mem_ack_i = 1'b0;
    step();
    chk("late_ack_req",  {31'b0, mem_req_o}, 32'h0);
    chk("late_ack_data", cpu_data_o,         32'h0);

    // Previously cached line must miss after reset.
    access(1'b0, 32'h0000_0044, 32'h0, 2, 2);
    chk("post_rst_stall", stall_cnt,  32'd4);
    chk("post_rst_raddr", rd_addr,    32'h0000_0040);
    chk("post_rst_data",  cpu_data_o, 32'hDEAD_BEEF);
    step();

    // Back-to-back hits across all eight words, request held high.
    for (int k = 0; k < 8; k++) begin
      access(1'b0, 32'h0000_0040 + 32'(k*4), 32'h0, 1, 1);
      chk($sformatf("b2b_stall_%0d", k), stall_cnt, 32'd0);
      chk($sformatf("b2b_data_%0d", k), cpu_data_o,
          (k == 1) ? 32'hDEAD_BEEF : {16'hC0DE, 16'h0040 + 16'(k*4)});
      step();
    end
    cpu_req_i = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
